csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every CSR and data port.
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0, reset value of mtvec.
REQ-003 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  12  read address.
- rdata  out  XLEN  read data.
- illegal_r  out  1  raddr is unmapped.
- waddr  in  12  write address.
- wdata  in  XLEN  write operand.
- csr_w  in  1  write enable.
- csr_wsc_mode  in  2  write mode: 01 write, 10 set, 11 clear, 00 none.
- illegal_w  out  1  write to an unmapped or read-only address.
- is_trap  in  1  trap entry.
- trap_pc  in  XLEN  trap PC.
- trap_cause  in  XLEN  cause value.
- trap_val  in  XLEN  tval value.
- is_mret  in  1  mret executes.
- retire  in  1  an instruction retires.
- irq_sw, irq_timer, irq_ext  in  1 each  interrupt lines.
- irq_req  out  1  interrupt pending and enabled.
- irq_cause  out  XLEN  cause of the highest-priority interrupt.
- trap_target  out  XLEN  trap handler PC.
- mepc_o  out  XLEN  current mepc.
- mstatus  out  XLEN  current mstatus.

Function
REQ-005 SHALL implement this address map (all others unmapped):
- mstatus 0x300; misa 0x301 (RO, 0x40000100); mie 0x304; mtvec 0x305.
- mscratch 0x340; mepc 0x341; mcause 0x342; mtval 0x343.
- mip 0x344 (RO); mhartid 0xF14 (RO).
- mcycle 0xB00; mcycleh 0xB80; minstret 0xB02; minstreth 0xB82.
REQ-006 SHALL read combinationally, returning the pre-edge state; an unmapped raddr SHALL give rdata=0 and illegal_r=1.
REQ-007 SHALL compute the new value as wdata for mode 01, old|wdata for mode 10 and old&~wdata for mode 11; mode 00 SHALL write nothing.
REQ-008 SHALL raise illegal_w combinationally when csr_w=1 with mode≠00 and waddr is unmapped or read-only, and SHALL then change no state.
REQ-009 SHALL apply these write masks:
- mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 11.
- mie: only bits 3, 7 and 11 are writable.
- mepc: bits[1:0] are forced to 0.
REQ-010 SHALL treat mtvec as WARL: a written mode of 1x SHALL store mode 00.
REQ-011 SHALL apply same-cycle events in priority order is_trap > is_mret > csr_w; a lower-priority event in that cycle is dropped.
REQ-012 On is_trap the block SHALL update, at the next edge:
- mepc ← trap_pc&~3; mcause ← trap_cause; mtval ← trap_val.
- MPIE ← MIE; MIE ← 0.
REQ-013 On is_mret the block SHALL set MIE ← MPIE and MPIE ← 1, leaving mepc, mcause and mtval unchanged.
REQ-014 SHALL drive trap_target combinationally:
- mtvec base + 4·mcause[4:0] when mtvec mode=01 and mcause[XLEN-1]=1.
- mtvec base (bits[1:0] cleared) otherwise.
REQ-015 SHALL register mip each cycle: MSIP[3] ← irq_sw, MTIP[7] ← irq_timer, MEIP[11] ← irq_ext (one-cycle latency).
REQ-016 SHALL drive irq_req = MIE & |(mip & mie).
REQ-017 SHALL drive irq_cause = {1, code}, with code chosen in priority order MEI(11) > MSI(3) > MTI(7); irq_cause is 0 when no interrupt is enabled and pending.
REQ-018 SHALL run two 64-bit counters, each wrapping to 0 after all-ones with carry propagating into the high half:
- mcycle increments every non-reset cycle.
- minstret increments when retire=1.
REQ-019 A CSR write to a counter half SHALL load that half and suppress that counter's increment for the cycle; the other half is held.

Reset
REQ-020 On a clk edge with rst=1 the block SHALL set:
- mstatus=0x00001800; mtvec=MTVEC_RST.
- all other writable CSRs, mip and both counters to 0.
- outputs consequently: irq_req=0, irq_cause=0, mepc_o=0.
REQ-021 rst SHALL override is_trap, is_mret and csr_w in the same cycle.

Structure
REQ-022 Package csr_pkg SHALL hold the CSR address constants, the mstatus/mip bit positions, the interrupt cause codes and the write-mode encodings.
REQ-023 SHALL use one sub-module, csr_counter64 (64-bit counter with increment, per-half load and wrap), instantiated twice.

Verification
REQ-024 Write 0x305 with wdata 0x80000003, mode 01 → mtvec reads 0x80000000.
REQ-025 mstatus MIE=1, mie=0x800, irq_ext high for one cycle, then the next cycle → irq_req=1 and irq_cause=0x8000000B.
REQ-026 Assert is_trap and csr_w (waddr 0x341) in the same cycle with trap_pc=0x1006 → mepc=0x1004, the write is dropped, MIE=0 and MPIE equals the old MIE.
REQ-027 mtvec=0x100 with mode 01, trap_cause=0x80000007 → trap_target=0x11C; after is_mret, MIE=1 again.
REQ-028 Write mcycle=0xFFFFFFFF, mcycleh=0 → two cycles later mcycleh=1 and mcycle=0x00000000; write to 0xF14 → illegal_w=1 and mhartid unchanged.
REQ-029 Assert rst mid-trap → every output takes its REQ-020 value at the next edge.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: address map, status and
// interrupt bit positions, interrupt cause codes and write-mode encodings.
package csr_pkg;

   // CSR address map
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   // misa: RV32I, 32-bit machine
   localparam logic [31:0] MISA_VAL = 32'h4000_0100;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // mip / mie bit positions
   localparam int MIP_MSI = 3;
   localparam int MIP_MTI = 7;
   localparam int MIP_MEI = 11;

   // interrupt cause codes (low bits of mcause)
   localparam logic [4:0] CAUSE_MSI = 5'd3;
   localparam logic [4:0] CAUSE_MTI = 5'd7;
   localparam logic [4:0] CAUSE_MEI = 5'd11;

   // CSR write modes
   typedef enum logic [1:0] {
      WMODE_NONE  = 2'b00,
      WMODE_WRITE = 2'b01,
      WMODE_SET   = 2'b10,
      WMODE_CLEAR = 2'b11
   } wmode_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half loads.
// A load on either half holds the other half and skips the increment.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        load_lo,
   input  logic        load_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   // Counter state: reset, load a half, or increment with natural 64-bit wrap.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load_lo || load_hi) begin
         if (load_lo) count[31:0]  <= wdata;
         if (load_hi) count[63:32] <= wdata;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, write/set/clear port,
// trap entry / mret sequencing, interrupt pending/enable logic and the
// mcycle / minstret counters.
module csr_file
   import csr_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] MTVEC_RST = '0,
   parameter int              HART_ID   = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     raddr,
   output logic [XLEN-1:0] rdata,
   output logic            illegal_r,
   input  logic [11:0]     waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            csr_w,
   input  logic [1:0]      csr_wsc_mode,
   output logic            illegal_w,
   input  logic            is_trap,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_val,
   input  logic            is_mret,
   input  logic            retire,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            irq_ext,
   output logic            irq_req,
   output logic [XLEN-1:0] irq_cause,
   output logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mstatus
);

   localparam logic [XLEN-1:0] IRQ_MASK = (XLEN'(1) << MIP_MSI) |
                                          (XLEN'(1) << MIP_MTI) |
                                          (XLEN'(1) << MIP_MEI);

   logic            mie_bit, mpie_bit;
   logic [XLEN-1:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r, mip_r;
   logic [63:0]     mcycle_q, minstret_q;

   logic [XLEN-1:0] rd_data, wr_old, wr_new, irq_pend, tvec_base;
   logic            rd_hit, wr_hit, wr_ro, wr_req, we;
   wmode_e          wmode;

   // Shared address decoder used by both the read port and the write old-value path.
   function automatic void csr_lookup(input logic [11:0] addr,
                                      output logic [XLEN-1:0] data,
                                      output logic hit);
      data = '0;
      hit  = 1'b1;
      case (addr)
         CSR_MSTATUS:   data = mstatus;
         CSR_MISA:      data = XLEN'(MISA_VAL);
         CSR_MIE:       data = mie_r;
         CSR_MTVEC:     data = mtvec_r;
         CSR_MSCRATCH:  data = mscratch_r;
         CSR_MEPC:      data = mepc_r;
         CSR_MCAUSE:    data = mcause_r;
         CSR_MTVAL:     data = mtval_r;
         CSR_MIP:       data = mip_r;
         CSR_MHARTID:   data = XLEN'(HART_ID);
         CSR_MCYCLE:    data = XLEN'(mcycle_q[31:0]);
         CSR_MCYCLEH:   data = XLEN'(mcycle_q[63:32]);
         CSR_MINSTRET:  data = XLEN'(minstret_q[31:0]);
         CSR_MINSTRETH: data = XLEN'(minstret_q[63:32]);
         default:       hit  = 1'b0;
      endcase
   endfunction

   // mstatus view: MPP hardwired to machine mode, only MIE/MPIE stored.
   // NOTE: every signal driven in always_comb gets a default first so no path infers a latch.
   always_comb begin
      mstatus               = '0;
      mstatus[12:11]        = 2'b11;
      mstatus[MSTATUS_MIE]  = mie_bit;
      mstatus[MSTATUS_MPIE] = mpie_bit;
   end

   // Decode read and write addresses against the current state.
   always_comb begin
      csr_lookup(raddr, rd_data, rd_hit);
      csr_lookup(waddr, wr_old, wr_hit);
   end

   assign rdata     = rd_data;
   assign illegal_r = !rd_hit;

   assign wmode     = wmode_e'(csr_wsc_mode);
   assign wr_ro     = (waddr == CSR_MISA) || (waddr == CSR_MIP) || (waddr == CSR_MHARTID);
   assign wr_req    = csr_w && (wmode != WMODE_NONE);
   assign illegal_w = wr_req && (!wr_hit || wr_ro);
   // trap and mret both take precedence over a CSR write in the same cycle
   assign we        = wr_req && !illegal_w && !is_trap && !is_mret;

   // New CSR value from the old value and the write operand.
   always_comb begin
      wr_new = wr_old;
      case (wmode)
         WMODE_WRITE: wr_new = wdata;
         WMODE_SET:   wr_new = wr_old | wdata;
         WMODE_CLEAR: wr_new = wr_old & ~wdata;
         default:     wr_new = wr_old;
      endcase
   end

   // Architectural CSR state: reset > trap entry > mret > CSR write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_bit    <= 1'b0;
         mpie_bit   <= 1'b0;
         mie_r      <= '0;
         mtvec_r    <= MTVEC_RST;
         mscratch_r <= '0;
         mepc_r     <= '0;
         mcause_r   <= '0;
         mtval_r    <= '0;
      end else if (is_trap) begin
         mepc_r   <= {trap_pc[XLEN-1:2], 2'b00};
         mcause_r <= trap_cause;
         mtval_r  <= trap_val;
         mpie_bit <= mie_bit;
         mie_bit  <= 1'b0;
      end else if (is_mret) begin
         mie_bit  <= mpie_bit;
         mpie_bit <= 1'b1;
      end else if (we) begin
         case (waddr)
            CSR_MSTATUS: begin
               mie_bit  <= wr_new[MSTATUS_MIE];
               mpie_bit <= wr_new[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_r      <= wr_new & IRQ_MASK;
            // reserved vector modes (1x) collapse to direct mode
            CSR_MTVEC:    mtvec_r    <= {wr_new[XLEN-1:2], wr_new[1] ? 2'b00 : wr_new[1:0]};
            CSR_MSCRATCH: mscratch_r <= wr_new;
            CSR_MEPC:     mepc_r     <= {wr_new[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_r   <= wr_new;
            CSR_MTVAL:    mtval_r    <= wr_new;
            default:      ;
         endcase
      end
   end

   // Sample the interrupt lines into mip every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mip_r <= '0;
      end else begin
         mip_r          <= '0;
         mip_r[MIP_MSI] <= irq_sw;
         mip_r[MIP_MTI] <= irq_timer;
         mip_r[MIP_MEI] <= irq_ext;
      end
   end

   assign irq_pend = mip_r & mie_r;
   assign irq_req  = mie_bit && (|irq_pend);

   // Highest-priority enabled and pending interrupt: MEI > MSI > MTI.
   always_comb begin
      irq_cause = '0;
      if (irq_pend[MIP_MEI]) begin
         irq_cause[XLEN-1] = 1'b1;
         irq_cause[4:0]    = CAUSE_MEI;
      end else if (irq_pend[MIP_MSI]) begin
         irq_cause[XLEN-1] = 1'b1;
         irq_cause[4:0]    = CAUSE_MSI;
      end else if (irq_pend[MIP_MTI]) begin
         irq_cause[XLEN-1] = 1'b1;
         irq_cause[4:0]    = CAUSE_MTI;
      end
   end

   // Handler address: vectored only for interrupts in mode 01.
   always_comb begin
      tvec_base   = {mtvec_r[XLEN-1:2], 2'b00};
      trap_target = tvec_base;
      if (mtvec_r[1:0] == 2'b01 && mcause_r[XLEN-1])
         trap_target = tvec_base + XLEN'({mcause_r[4:0], 2'b00});
   end

   assign mepc_o = mepc_r;

   csr_counter64 u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc     (1'b1),
      .load_lo (we && (waddr == CSR_MCYCLE)),
      .load_hi (we && (waddr == CSR_MCYCLEH)),
      .wdata   (wr_new[31:0]),
      .count   (mcycle_q)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc     (retire),
      .load_lo (we && (waddr == CSR_MINSTRET)),
      .load_hi (we && (waddr == CSR_MINSTRETH)),
      .wdata   (wr_new[31:0]),
      .count   (minstret_q)
   );

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: a table of single-write vectors checked
// through a scoreboard queue, followed by hand-written multi-cycle sequences
// for interrupts, trap/mret, counters and reset.
module tb_csr_file;

   localparam int          XLEN      = 32;
   localparam logic [31:0] MTVEC_RST = 32'h0000_0040;
   localparam int          HART_ID   = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] raddr = '0, waddr = '0;
   logic [31:0] rdata, wdata = '0;
   logic        illegal_r, illegal_w;
   logic        csr_w = 1'b0;
   logic [1:0]  csr_wsc_mode = 2'b00;
   logic        is_trap = 1'b0, is_mret = 1'b0, retire = 1'b0;
   logic [31:0] trap_pc = '0, trap_cause = '0, trap_val = '0;
   logic        irq_sw = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
   logic        irq_req;
   logic [31:0] irq_cause, trap_target, mepc_o, mstatus;

   always #5 clk = ~clk;

   csr_file #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
      .clk(clk), .rst(rst),
      .raddr(raddr), .rdata(rdata), .illegal_r(illegal_r),
      .waddr(waddr), .wdata(wdata), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
      .illegal_w(illegal_w),
      .is_trap(is_trap), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
      .is_mret(is_mret), .retire(retire),
      .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
      .irq_req(irq_req), .irq_cause(irq_cause), .trap_target(trap_target),
      .mepc_o(mepc_o), .mstatus(mstatus)
   );

   typedef struct {
      logic        w;
      logic [1:0]  mode;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic [11:0] raddr;
      logic [31:0] exp_rdata;
      logic        exp_illr;
      logic        exp_illw;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        illr;
   } exp_t;

   vec_t vecs[20];
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
      csr_w = 1'b1; csr_wsc_mode = 2'b01; waddr = a; wdata = d;
      tick();
      csr_w = 1'b0; csr_wsc_mode = 2'b00;
   endtask

   task automatic check_read(input string name, input logic [11:0] a, input logic [31:0] exp);
      raddr = a;
      #1;
      check(name, rdata, exp);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      exp_t e;
      csr_w = v.w; csr_wsc_mode = v.mode; waddr = v.waddr; wdata = v.wdata; raddr = v.raddr;
      exp_q.push_back('{v.exp_rdata, v.exp_illr});
      #3;
      check($sformatf("vec%0d illegal_w", idx), 32'(illegal_w), 32'(v.exp_illw));
      tick();
      csr_w = 1'b0; csr_wsc_mode = 2'b00;
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d rdata", idx), rdata, e.rdata);
      check($sformatf("vec%0d illegal_r", idx), 32'(illegal_r), 32'(e.illr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // w, mode, waddr, wdata, raddr, exp_rdata, exp_illr, exp_illw
      vecs[0]  = '{1'b1, 2'b01, 12'h305, 32'h8000_0003, 12'h305, 32'h8000_0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 2'b01, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 2'b10, 12'h340, 32'h0000_0010, 12'h340, 32'hDEAD_BEFF, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 2'b11, 12'h340, 32'hDEAD_0000, 12'h340, 32'h0000_BEFF, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 2'b00, 12'h340, 32'h1234_5678, 12'h340, 32'h0000_BEFF, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 2'b01, 12'h340, 32'hFFFF_FFFF, 12'h340, 32'h0000_BEFF, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 2'b11, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1880, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 2'b01, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 2'b01, 12'h341, 32'h0000_1237, 12'h341, 32'h0000_1234, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 2'b01, 12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 2'b01, 12'hF14, 32'h0000_0055, 12'hF14, 32'h0000_0005, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 2'b01, 12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 2'b01, 12'h305, 32'h0000_0102, 12'h305, 32'h0000_0100, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 2'b01, 12'h305, 32'h0000_0101, 12'h305, 32'h0000_0101, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 2'b01, 12'h344, 32'h0000_0888, 12'h344, 32'h0000_0000, 1'b0, 1'b1};
      vecs[16] = '{1'b1, 2'b01, 12'h342, 32'h8000_0007, 12'h342, 32'h8000_0007, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 2'b01, 12'h343, 32'h0000_CAFE, 12'h343, 32'h0000_CAFE, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 2'b11, 12'h304, 32'h0000_0808, 12'h304, 32'h0000_0080, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 2'b00, 12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0000_0000, 1'b1, 1'b0};

      // ---- reset state ----
      tick(); tick();
      check("rst mstatus", mstatus, 32'h0000_1800);
      check("rst irq_req", 32'(irq_req), 32'h0);
      check("rst irq_cause", irq_cause, 32'h0);
      check("rst mepc_o", mepc_o, 32'h0);
      check("rst trap_target", trap_target, MTVEC_RST);
      check_read("rst mtvec", 12'h305, MTVEC_RST);
      check_read("rst mhartid", 12'hF14, 32'(HART_ID));
      rst = 1'b0;
      tick();
      check_read("mcycle first count", 12'hB00, 32'h1);

      // ---- table-driven single writes ----
      for (int i = 0; i < 20; i++) apply_vec(vecs[i], i);
      check("tbl trap_target", trap_target, 32'h0000_011C);
      check("tbl mepc_o", mepc_o, 32'h0000_1234);
      check("tbl mstatus", mstatus, 32'h0000_1880);

      // ---- interrupts ----
      write_csr(12'h300, 32'h8);
      write_csr(12'h304, 32'h800);
      irq_ext = 1'b1;
      tick();
      irq_ext = 1'b0;
      check("irq ext req", 32'(irq_req), 32'h1);
      check("irq ext cause", irq_cause, 32'h8000_000B);
      tick();
      check("irq ext dropped req", 32'(irq_req), 32'h0);
      check("irq ext dropped cause", irq_cause, 32'h0);
      write_csr(12'h304, 32'h888);
      irq_sw = 1'b1; irq_timer = 1'b1;
      tick();
      check("irq sw>timer cause", irq_cause, 32'h8000_0003);
      irq_ext = 1'b1;
      tick();
      check("irq ext>sw cause", irq_cause, 32'h8000_000B);
      irq_sw = 1'b0; irq_ext = 1'b0;
      tick();
      check("irq timer only cause", irq_cause, 32'h8000_0007);
      write_csr(12'h300, 32'h0);
      check("irq global disable", 32'(irq_req), 32'h0);
      irq_timer = 1'b0;
      tick();

      // ---- trap with a same-cycle CSR write, then mret with a write ----
      write_csr(12'h300, 32'h8);
      is_trap = 1'b1; trap_pc = 32'h1006; trap_cause = 32'h8000_0007; trap_val = 32'h0BAD;
      csr_w = 1'b1; csr_wsc_mode = 2'b01; waddr = 12'h341; wdata = 32'h9990;
      tick();
      is_trap = 1'b0; csr_w = 1'b0; csr_wsc_mode = 2'b00;
      check("trap mepc", mepc_o, 32'h0000_1004);
      check("trap mstatus", mstatus, 32'h0000_1880);
      check("trap target vectored", trap_target, 32'h0000_011C);
      check_read("trap mcause", 12'h342, 32'h8000_0007);
      check_read("trap mtval", 12'h343, 32'h0000_0BAD);
      is_mret = 1'b1;
      csr_w = 1'b1; csr_wsc_mode = 2'b01; waddr = 12'h340; wdata = 32'h0;
      tick();
      is_mret = 1'b0; csr_w = 1'b0; csr_wsc_mode = 2'b00;
      check("mret mstatus", mstatus, 32'h0000_1888);
      check("mret mepc held", mepc_o, 32'h0000_1004);
      check_read("mret write dropped", 12'h340, 32'h0000_BEFF);
      check_read("mret mcause held", 12'h342, 32'h8000_0007);
      is_trap = 1'b1; trap_pc = 32'h2000; trap_cause = 32'h2; trap_val = 32'h0;
      tick();
      is_trap = 1'b0;
      check("exc target direct", trap_target, 32'h0000_0100);
      check("exc mepc", mepc_o, 32'h0000_2000);

      // ---- counters ----
      write_csr(12'hB00, 32'hFFFF_FFFF);
      write_csr(12'hB80, 32'h0);
      check_read("mcycle held on hi load", 12'hB00, 32'hFFFF_FFFF);
      tick();
      check_read("mcycle wrapped lo", 12'hB00, 32'h0);
      check_read("mcycle carry hi", 12'hB80, 32'h1);
      write_csr(12'hB80, 32'h7);
      check_read("mcycleh load lo held", 12'hB00, 32'h0);
      check_read("mcycleh load", 12'hB80, 32'h7);
      retire = 1'b1;
      write_csr(12'hB02, 32'h5);
      check_read("minstret load wins", 12'hB02, 32'h5);
      tick(); tick(); tick();
      retire = 1'b0;
      tick();
      check_read("minstret retire count", 12'hB02, 32'h8);
      write_csr(12'hB02, 32'hFFFF_FFFF);
      write_csr(12'hB82, 32'hFFFF_FFFF);
      retire = 1'b1;
      tick();
      retire = 1'b0;
      check_read("minstret wrap lo", 12'hB02, 32'h0);
      check_read("minstret wrap hi", 12'hB82, 32'h0);

      // ---- reset in the middle of a trap ----
      write_csr(12'h300, 32'h8);
      write_csr(12'h304, 32'h80);
      irq_timer = 1'b1;
      tick();
      check("pre-rst irq_req", 32'(irq_req), 32'h1);
      rst = 1'b1; is_trap = 1'b1; trap_pc = 32'h3000; trap_cause = 32'h8000_0003;
      csr_w = 1'b1; csr_wsc_mode = 2'b01; waddr = 12'h340; wdata = 32'h1111;
      tick();
      is_trap = 1'b0; csr_w = 1'b0; csr_wsc_mode = 2'b00;
      check("mid-trap rst irq_req", 32'(irq_req), 32'h0);
      check("mid-trap rst irq_cause", irq_cause, 32'h0);
      check("mid-trap rst mepc_o", mepc_o, 32'h0);
      check("mid-trap rst mstatus", mstatus, 32'h0000_1800);
      check("mid-trap rst trap_target", trap_target, MTVEC_RST);
      check_read("mid-trap rst mscratch", 12'h340, 32'h0);
      check_read("mid-trap rst mcycle", 12'hB00, 32'h0);
      check_read("mid-trap rst mip", 12'h344, 32'h0);
      rst = 1'b0; irq_timer = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
